// File: rtl/pipe_addsub_nbit_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   AluOpAdd/AluOpSub : encodings for in_sub
//   FlagN/FlagZ/FlagV : bit positions inside out_flags
//   flags_t           : {N,Z,V} flag vector type
package pipe_addsub_nbit_pkg;

  localparam logic AluOpAdd = 1'b0;
  localparam logic AluOpSub = 1'b1;

  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/pipe_addsub_nbit_if.sv
// Operand/result handshake bundle for pipe_addsub_nbit.
//   master : producer of operands and consumer of results (drives in_*, out_ready)
//   slave  : the adder itself (drives in_ready, out_*)
interface pipe_addsub_nbit_if
  import pipe_addsub_nbit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  flags_t           out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_flags
  );

endinterface

// File: rtl/fulladder.sv
// One-bit full adder cell.
//   a, b, cin : addends and carry in
//   sum, cout : sum bit and carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_addsub_stage.sv
// Combinational CW-bit ripple-carry adder built from fulladder cells; one per pipeline stage.
//   a, b : CW-bit addends (b already conditionally inverted by the caller)
//   cin  : carry in
//   sum  : CW-bit sum
//   cout : carry out of the chunk MSB
module pipe_addsub_stage #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_bit
    fulladder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[CW];

endmodule

// File: rtl/pipe_addsub_nbit.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES equal chunks. Stage k adds chunk k
// and registers its carry; upper operand chunks ride forward in skew registers and finished
// lower sum chunks ride in de-skew registers so the final stage presents a coherent sum.
// Handshake: in_ready = !(out_valid && !out_ready); the whole pipe holds on a stall.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, discards every in-flight beat
//   bus_io : pipe_addsub_nbit_if slave (in_valid/in_ready/in_a/in_b/in_sub,
//            out_valid/out_ready/out_sum/out_cout/out_flags)
// Optional feature: define PIPE_ADDSUB_FLAGS_EN to register {N,Z,V} flags; otherwise
// out_flags is tied to zero.
module pipe_addsub_nbit
  import pipe_addsub_nbit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic                clk,
  input  logic                rst,
  pipe_addsub_nbit_if.slave   bus_io
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic last_valid;
  logic stall;
  logic en;

  assign stall           = last_valid && !bus_io.out_ready;
  assign en              = !stall;
  assign bus_io.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned Lo  = k * CW;     // sum bits finished before this stage
    localparam int unsigned Rem = WIDTH - Lo; // operand bits still to be added

    logic [Rem-1:0]     a_in;
    logic [Rem-1:0]     b_in;
    logic               sub_in;
    logic               cin_in;
    logic               vld_in;
    logic [CW-1:0]      b_chunk;
    logic [CW-1:0]      s_chunk;
    logic               c_out;
    logic [Lo+CW-1:0]   sum_d;
    logic [Lo+CW-1:0]   sum_q;
    logic               carry_q;
    logic               valid_q;

    if (k == 0) begin : g_src
      assign a_in   = bus_io.in_a;
      assign b_in   = bus_io.in_b;
      assign sub_in = bus_io.in_sub;
      assign cin_in = bus_io.in_sub;  // +1 of the two's complement
      assign vld_in = bus_io.in_valid;
      assign sum_d  = s_chunk;
    end else begin : g_src
      assign a_in   = g_st[k-1].g_skew.a_q;
      assign b_in   = g_st[k-1].g_skew.b_q;
      assign sub_in = g_st[k-1].g_skew.sub_q;
      assign cin_in = g_st[k-1].carry_q;
      assign vld_in = g_st[k-1].valid_q;
      assign sum_d  = {s_chunk, g_st[k-1].sum_q};
    end

    assign b_chunk = b_in[CW-1:0] ^ {CW{sub_in}};

    pipe_addsub_stage #(
      .CW(CW)
    ) u_stage (
      .a   (a_in[CW-1:0]),
      .b   (b_chunk),
      .cin (cin_in),
      .sum (s_chunk),
      .cout(c_out)
    );

`ifdef PIPE_ADDSUB_FLAGS_EN
    // Running "any bit nonzero" so Z never needs a WIDTH-wide reduction.
    logic nz_prev;
    logic nz_d;
    if (k == 0) begin : g_nz
      assign nz_prev = 1'b0;
    end else begin : g_nz
      assign nz_prev = g_st[k-1].g_skew.nz_q;
    end
    assign nz_d = nz_prev | (|s_chunk);
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= vld_in;
        carry_q <= c_out;
        sum_q   <= sum_d;
      end
    end

    // Upper operand chunks only exist while something is left to add.
    if (k < STAGES - 1) begin : g_skew
      logic [Rem-CW-1:0] a_q;
      logic [Rem-CW-1:0] b_q;
      logic              sub_q;
`ifdef PIPE_ADDSUB_FLAGS_EN
      logic              nz_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          nz_q <= 1'b0;
        end else if (en) begin
          nz_q <= nz_d;
        end
      end
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (en) begin
          a_q   <= a_in[Rem-1:CW];
          b_q   <= b_in[Rem-1:CW];
          sub_q <= sub_in;
        end
      end
    end
  end

  assign last_valid       = g_st[STAGES-1].valid_q;
  assign bus_io.out_valid = last_valid;
  assign bus_io.out_sum   = g_st[STAGES-1].sum_q;
  assign bus_io.out_cout  = g_st[STAGES-1].carry_q;

`ifdef PIPE_ADDSUB_FLAGS_EN
  flags_t flags_d;
  flags_t flags_q;
  logic   a_msb;
  logic   b_msb;
  logic   s_msb;

  assign a_msb = g_st[STAGES-1].a_in[CW-1];
  assign b_msb = g_st[STAGES-1].b_chunk[CW-1];
  assign s_msb = g_st[STAGES-1].s_chunk[CW-1];

  always_comb begin
    flags_d        = '0;
    flags_d[FlagN] = s_msb;
    flags_d[FlagZ] = !g_st[STAGES-1].nz_d;
    flags_d[FlagV] = (a_msb == b_msb) && (s_msb != a_msb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (en) begin
      flags_q <= flags_d;
    end
  end

  assign bus_io.out_flags = flags_q;
`else
  assign bus_io.out_flags = '0;
`endif

endmodule

// File: tb/tb_pipe_addsub_nbit.sv
// Directed self-checking bench for pipe_addsub_nbit (WIDTH=32). Change STAGES or define
// PIPE_ADDSUB_FLAGS_EN to cover the other configurations; flag expectations are masked to
// zero when the flag feature is not built.
module tb_pipe_addsub_nbit;
  import pipe_addsub_nbit_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;
`ifdef PIPE_ADDSUB_FLAGS_EN
  localparam logic [2:0] FlagMask = 3'b111;
`else
  localparam logic [2:0] FlagMask = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pipe_addsub_nbit_if #(.WIDTH(WIDTH)) bus ();

  pipe_addsub_nbit #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (pipe assumed able to accept), then wait boundedly for out_valid.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output int lat);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_sum !== 32'h0) begin bad++; $display("FAIL reset_out_sum got=%h exp=0", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout got=%b exp=0", bus.out_cout); end
    total++; if (bus.out_flags !== 3'b000) begin bad++; $display("FAIL reset_out_flags got=%b exp=000", bus.out_flags); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add_carry();
    int lat;
    run_one(32'h0000_FFFF, 32'h0000_0001, AluOpAdd, lat);
    total++; if (lat != STAGES) begin bad++; $display("FAIL add_carry_latency got=%0d exp=%0d", lat, STAGES); end
    total++; if (bus.out_sum !== 32'h0001_0000) begin bad++; $display("FAIL add_carry_sum got=%h exp=00010000", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL add_carry_cout got=%b exp=0", bus.out_cout); end
    total++; if (bus.out_flags !== (3'b000 & FlagMask)) begin bad++; $display("FAIL add_carry_flags got=%b exp=%b", bus.out_flags, 3'b000 & FlagMask); end
    tick();
  endtask

  task automatic test_sub();
    int lat;
    run_one(32'h0000_0005, 32'h0000_0007, AluOpSub, lat);
    total++; if (lat != STAGES) begin bad++; $display("FAIL sub_neg_latency got=%0d exp=%0d", lat, STAGES); end
    total++; if (bus.out_sum !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_neg_sum got=%h exp=fffffffe", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL sub_neg_cout got=%b exp=0", bus.out_cout); end
    total++; if (bus.out_flags !== (3'b100 & FlagMask)) begin bad++; $display("FAIL sub_neg_flags got=%b exp=%b", bus.out_flags, 3'b100 & FlagMask); end
    run_one(32'h8000_0000, 32'h0000_0001, AluOpSub, lat);
    total++; if (bus.out_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_ovf_sum got=%h exp=7fffffff", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b1) begin bad++; $display("FAIL sub_ovf_cout got=%b exp=1", bus.out_cout); end
    total++; if (bus.out_flags !== (3'b001 & FlagMask)) begin bad++; $display("FAIL sub_ovf_flags got=%b exp=%b", bus.out_flags, 3'b001 & FlagMask); end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    run_one(32'hFFFF_FFFF, 32'h0000_0001, AluOpAdd, lat);
    total++; if (bus.out_sum !== 32'h0000_0000) begin bad++; $display("FAIL wrap_sum got=%h exp=00000000", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b1) begin bad++; $display("FAIL wrap_cout got=%b exp=1", bus.out_cout); end
    total++; if (bus.out_flags !== (3'b010 & FlagMask)) begin bad++; $display("FAIL wrap_flags got=%b exp=%b", bus.out_flags, 3'b010 & FlagMask); end
    run_one(32'h7FFF_FFFF, 32'h0000_0001, AluOpAdd, lat);
    total++; if (bus.out_sum !== 32'h8000_0000) begin bad++; $display("FAIL sovf_sum got=%h exp=80000000", bus.out_sum); end
    total++; if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL sovf_cout got=%b exp=0", bus.out_cout); end
    total++; if (bus.out_flags !== (3'b101 & FlagMask)) begin bad++; $display("FAIL sovf_flags got=%b exp=%b", bus.out_flags, 3'b101 & FlagMask); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [8] = '{32'h1234_5678, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0F0F_0F0F,
                            32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h00FF_00FF};
    logic [31:0] tb [8] = '{32'h1111_1111, 32'h0000_0001, 32'h0000_0002, 32'hF0F0_F0F0,
                            32'h0000_0001, 32'h8000_0000, 32'h0000_BEEF, 32'h0001_0001};
    logic        ts [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [8] = '{32'h2345_6789, 32'h0000_000F, 32'h0000_0001, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_0000, 32'h0100_0100};
    logic [31:0] q [$];
    logic [31:0] exp_sum;
    bit          ev [STAGES];
    bit          exp_stall;
    bit          acc;
    int          sent = 0;
    int          got  = 0;
    int          c    = 0;
    foreach (ev[k]) ev[k] = 1'b0;
    while (got < 8 && c < 200) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_a   = ta[sent];
        bus.in_b   = tb[sent];
        bus.in_sub = ts[sent];
      end
      #1;
      exp_stall = ev[STAGES-1] && !bus.out_ready;
      total++; if (bus.in_ready !== !exp_stall) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, !exp_stall); end
      total++; if (bus.out_valid !== ev[STAGES-1]) begin bad++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, ev[STAGES-1]); end
      if (ev[STAGES-1] && bus.out_ready) begin
        exp_sum = (q.size() > 0) ? q.pop_front() : 32'hX;
        total++; if (bus.out_sum !== exp_sum) begin bad++; $display("FAIL b2b_sum beat=%0d got=%h exp=%h", got, bus.out_sum, exp_sum); end
        got++;
      end
      acc = bus.in_valid && !exp_stall;
      if (acc) begin
        q.push_back(te[sent]);
        sent++;
      end
      tick();
      if (!exp_stall) begin
        for (int k = STAGES - 1; k > 0; k--) ev[k] = ev[k-1];
        ev[0] = acc;
      end
      c++;
    end
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midflight();
    int lat;
    int stray = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h0000_0100 * (i + 1);
      bus.in_b     = 32'h0000_0010;
      bus.in_sub   = AluOpAdd;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_sum !== 32'h0) begin bad++; $display("FAIL midrst_out_sum got=%h exp=0", bus.out_sum); end
    @(posedge clk);
    #1 rst = 1'b0;
    run_one(32'h0000_0001, 32'h0000_0002, AluOpAdd, lat);
    total++; if (lat != STAGES) begin bad++; $display("FAIL midrst_new_latency got=%0d exp=%0d", lat, STAGES); end
    total++; if (bus.out_sum !== 32'h0000_0003) begin bad++; $display("FAIL midrst_new_sum got=%h exp=00000003", bus.out_sum); end
    for (int i = 0; i < 2 * STAGES + 4; i++) begin
      tick();
      if (bus.out_valid === 1'b1) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL midrst_stray_beats got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
